// File: rtl/key_debounce_pkg.sv
// Shared types and default timing for the key debounce array (12 MHz system clock).
package key_debounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } deb_state_e;

  localparam int DEF_CLK_HZ     = 12_000_000;
  localparam int DEF_N_KEYS     = 4;
  localparam int DEF_CNT_W      = 24;
  localparam int DEF_DEB_CYC    = 240_000;     // 20 ms
  localparam int DEF_LONG_CYC   = 12_000_000;  // 1 s
  localparam int DEF_REPEAT_CYC = 2_400_000;   // 200 ms

  // Debounced level is "down" in both states that follow an accepted press.
  function automatic logic is_down(deb_state_e s);
    return (s == ST_PRESSED) || (s == ST_RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/key_debounce_array_if.sv
// Key inputs and debounced event outputs of the array; dbg_state exposes each channel FSM.
interface key_debounce_array_if #(
  parameter int N_KEYS = 4
);
  logic [N_KEYS-1:0]      key;
  logic [N_KEYS-1:0]      key_state;
  logic [N_KEYS-1:0]      press_pulse;
  logic [N_KEYS-1:0]      release_pulse;
  logic [N_KEYS-1:0]      long_pulse;
  logic [N_KEYS-1:0]      repeat_pulse;
  logic [N_KEYS-1:0][1:0] dbg_state;

  // No handshake: key is a raw level, every output is a registered level or one-cycle pulse.
  modport master (
    output key,
    input  key_state, press_pulse, release_pulse, long_pulse, repeat_pulse, dbg_state
  );

  modport slave (
    input  key,
    output key_state, press_pulse, release_pulse, long_pulse, repeat_pulse, dbg_state
  );
endinterface

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, debounce FSM, long-press and auto-repeat timing.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int DEB_CYC    = DEF_DEB_CYC,
  parameter int LONG_CYC   = DEF_LONG_CYC,
  parameter int REPEAT_CYC = DEF_REPEAT_CYC,
  parameter int REPEAT_EN  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_key,
  output logic       o_key_state,
  output logic       o_press_pulse,
  output logic       o_release_pulse,
  output logic       o_long_pulse,
  output logic       o_repeat_pulse,
  output deb_state_e o_dbg_state
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic             r_sync1, r_sync2;
  deb_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_long_done, w_long_done_nxt;
  logic             r_key_state, r_press, r_release, r_long, r_repeat;
  logic             w_press_nxt, w_release_nxt, w_long_nxt, w_repeat_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_long_done <= 1'b0;
      r_key_state <= 1'b0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_long      <= 1'b0;
      r_repeat    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_long_done <= w_long_done_nxt;
      r_key_state <= is_down(w_state_nxt);
      r_press     <= w_press_nxt;
      r_release   <= w_release_nxt;
      r_long      <= w_long_nxt;
      r_repeat    <= w_repeat_nxt;
    end
  end

  // Key is active-low after synchronisation: r_sync2 == 0 means held down.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt + CNT_W'(1);
    w_long_done_nxt = r_long_done;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (!r_sync2) w_state_nxt = ST_PRESS_WAIT;
      end
      ST_PRESS_WAIT: begin
        if (r_sync2) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_state_nxt = ST_PRESSED;
          w_cnt_nxt   = '0;
        end
      end
      ST_PRESSED: begin
        if (r_sync2) begin
          w_state_nxt = ST_RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end else if (!r_long_done) begin
          if (r_cnt == LONG_LAST) begin
            w_cnt_nxt       = '0;
            w_long_done_nxt = 1'b1;
          end
        end else if (REPEAT_EN != 0) begin
          if (r_cnt == REP_LAST) w_cnt_nxt = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_cnt_nxt = r_cnt;
        end
      end
      ST_RELEASE_WAIT: begin
        if (!r_sync2) begin
          w_state_nxt = ST_PRESSED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_state_nxt     = ST_IDLE;
          w_cnt_nxt       = '0;
          w_long_done_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_long_nxt    = 1'b0;
    w_repeat_nxt  = 1'b0;
    case (r_state)
      ST_PRESS_WAIT:   w_press_nxt   = !r_sync2 && (r_cnt == DEB_LAST);
      ST_RELEASE_WAIT: w_release_nxt = r_sync2 && (r_cnt == DEB_LAST);
      ST_PRESSED: begin
        w_long_nxt   = !r_sync2 && !r_long_done && (r_cnt == LONG_LAST);
        w_repeat_nxt = !r_sync2 && r_long_done && (REPEAT_EN != 0) && (r_cnt == REP_LAST);
      end
      default: ;
    endcase
  end

  assign o_key_state     = r_key_state;
  assign o_press_pulse   = r_press;
  assign o_release_pulse = r_release;
  assign o_long_pulse    = r_long;
  assign o_repeat_pulse  = r_repeat;
  assign o_dbg_state     = r_state;

endmodule

// File: rtl/key_debounce_array.sv
// N_KEYS independent debounce channels sharing one clock and reset.
module key_debounce_array
  import key_debounce_pkg::*;
#(
  parameter int N_KEYS     = DEF_N_KEYS,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int DEB_CYC    = DEF_DEB_CYC,
  parameter int LONG_CYC   = DEF_LONG_CYC,
  parameter int REPEAT_CYC = DEF_REPEAT_CYC,
  parameter int REPEAT_EN  = 1
) (
  input logic                  clk,
  input logic                  rst,
  key_debounce_array_if.slave  bus
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    deb_state_e w_dbg_state;

    key_debounce_ch #(
      .CNT_W      (CNT_W),
      .DEB_CYC    (DEB_CYC),
      .LONG_CYC   (LONG_CYC),
      .REPEAT_CYC (REPEAT_CYC),
      .REPEAT_EN  (REPEAT_EN)
    ) u_ch (
      .clk             (clk),
      .rst             (rst),
      .i_key           (bus.key[i]),
      .o_key_state     (bus.key_state[i]),
      .o_press_pulse   (bus.press_pulse[i]),
      .o_release_pulse (bus.release_pulse[i]),
      .o_long_pulse    (bus.long_pulse[i]),
      .o_repeat_pulse  (bus.repeat_pulse[i]),
      .o_dbg_state     (w_dbg_state)
    );

    assign bus.dbg_state[i] = w_dbg_state;
  end

endmodule

// File: doc/key_debounce_array.md
KEY_DEBOUNCE_ARRAY -- requirements
Module: key_debounce_array

Interface
REQ-001 Parameter N_KEYS, default 4, number of independent key channels (1..16).
REQ-002 Parameter CNT_W, default 24, per-channel counter width; SHALL hold max(DEB_CYC, LONG_CYC, REPEAT_CYC).
REQ-003 Parameter DEB_CYC, default 240000, debounce stable time in clk cycles (20 ms at 12 MHz); minimum 2.
REQ-004 Parameter LONG_CYC, default 12000000, hold time for long-press event in cycles (1 s at 12 MHz); minimum 2.
REQ-005 Parameter REPEAT_CYC, default 2400000, auto-repeat period after long press in cycles (200 ms); minimum 2.
REQ-006 Parameter REPEAT_EN, default 1, 1 = auto-repeat enabled, 0 = no repeat pulses.
REQ-007 clk  input  1  system clock, all logic on rising edge.
REQ-008 rst  input  1  asynchronous, active-low reset.
REQ-009 key  input  N_KEYS  raw asynchronous keys, active-low (released = 1).
REQ-010 key_state  output  N_KEYS  debounced level, 1 = pressed.
REQ-011 press_pulse  output  N_KEYS  one-cycle pulse on debounced press.
REQ-012 release_pulse  output  N_KEYS  one-cycle pulse on debounced release.
REQ-013 long_pulse  output  N_KEYS  one-cycle pulse when hold reaches LONG_CYC.
REQ-014 repeat_pulse  output  N_KEYS  one-cycle pulse every REPEAT_CYC after long_pulse while held.

Function
REQ-015 Each channel SHALL synchronise key[i] through two flops (reset value 1) before any use; channels fully independent.
REQ-016 Each channel SHALL run FSM states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT, plus counter cnt[CNT_W] and flag long_done.
REQ-017 IDLE: synced key = 0 -> PRESS_WAIT, cnt = 0.
REQ-018 PRESS_WAIT: synced key = 1 -> IDLE, no pulse (bounce rejected); cnt = DEB_CYC-1 with key = 0 -> PRESSED, cnt = 0, press_pulse = 1 for one cycle; otherwise cnt+1.
REQ-019 Press latency: key stable low before edge E1 -> press_pulse registered at edge E1+DEB_CYC+2, high exactly one cycle.
REQ-020 PRESSED: synced key = 1 -> RELEASE_WAIT, cnt = 0; else cnt+1, except as REQ-021/022.
REQ-021 PRESSED, long_done = 0, cnt = LONG_CYC-1 -> long_pulse = 1 one cycle, long_done = 1, cnt = 0.
REQ-022 PRESSED, long_done = 1, REPEAT_EN = 1, cnt = REPEAT_CYC-1 -> repeat_pulse = 1 one cycle, cnt = 0; REPEAT_EN = 0 -> cnt saturates at all-ones, no pulse.
REQ-023 RELEASE_WAIT: synced key = 0 -> PRESSED, cnt = 0, long_done kept, no pulse; cnt = DEB_CYC-1 with key = 1 -> IDLE, release_pulse = 1 one cycle, long_done = 0; otherwise cnt+1.
REQ-024 key_state = 1 in PRESSED and RELEASE_WAIT, 0 otherwise; changes on same edge as press_pulse/release_pulse.
REQ-025 At most one of press/release/long/repeat pulse SHALL be high per channel per cycle; all outputs registered.
REQ-026 Simultaneous events on different channels SHALL be reported in the same cycle without interference.

Reset
REQ-027 rst = 0 SHALL force: sync flops 1, state IDLE, cnt 0, long_done 0, all outputs 0, asynchronously.
REQ-028 Reset mid-press SHALL emit no release_pulse; key still held after reset release SHALL produce a new press_pulse after DEB_CYC+2 cycles.

Structure
REQ-029 Shared package key_debounce_pkg SHALL hold FSM state enum (2-bit) and default timing constants for 12 MHz.
REQ-030 Per-channel logic SHALL be sub-module key_debounce_ch, instantiated N_KEYS times by a generate loop.

Verification (DEB_CYC=8, LONG_CYC=32, REPEAT_CYC=8, N_KEYS=4)
REQ-031 key[0] low at edge 10, held -> press_pulse[0] at edge 20, key_state[0]=1 from edge 20, others idle.
REQ-032 key[1] low 5 cycles then high (bounce) -> no pulse, key_state[1] stays 0.
REQ-033 key[2] held 80 cycles from press -> long_pulse at press+32, repeat_pulse at press+40, +48, +56, ...; release -> release_pulse 10 cycles after key high.
REQ-034 Release bounce: key[3] high 4 cycles during PRESSED then low -> no release_pulse, key_state[3] stays 1.
REQ-035 rst asserted while key[0] in PRESSED -> all outputs 0 immediately; rst released with key held -> press_pulse[0] 10 cycles later.
REQ-036 All four keys pressed on same edge -> four press_pulse bits high on same cycle.
